// File: rtl/uart_cfg_sequencer_if.sv
// ============================================================================
//  Module   : uart_cfg_sequencer_if
//  Purpose  : Groups the host write-request channel and the regfile
//             valid/address/data/ack channel used by uart_cfg_sequencer.
//  Signals  : host_req/host_addr/host_data -> sequencer, host_done <- sequencer
//             cfg_valid/cfg_addr/cfg_data <- sequencer, cfg_ack -> sequencer
//  Modports : master = sequencer side, slave = host + regfile side
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface uart_cfg_sequencer_if;
  logic       host_req;
  logic [3:0] host_addr;
  logic [3:0] host_data;
  logic       host_done;
  logic       cfg_valid;
  logic [3:0] cfg_addr;
  logic [3:0] cfg_data;
  logic       cfg_ack;

  modport master (
    input  host_req, host_addr, host_data, cfg_ack,
    output host_done, cfg_valid, cfg_addr, cfg_data
  );

  modport slave (
    output host_req, host_addr, host_data, cfg_ack,
    input  host_done, cfg_valid, cfg_addr, cfg_data
  );
endinterface

`default_nettype wire

// File: rtl/uart_cfg_sequencer.sv
// ============================================================================
//  Module   : uart_cfg_sequencer
//  Purpose  : Configuration controller for the UART regfile write port.
//             After reset and on every accepted start pulse it writes the
//             four default framing registers (addr 0..3); otherwise it
//             grants single host write requests onto the same port.
//  Ports    : clk_16bd     16x baud clock (sole clock)
//             rst          synchronous active-high reset
//             start        one-cycle pulse, re-runs the boot sequence
//             bus          host request + regfile handshake (master modport)
//             busy         high whenever not idle
//             boot_done    set when a boot sequence completes
//             timeout_err  sticky ack-timeout flag
//             shadow_cfg   last written framing fields (optional)
//  Options  : UART_CFG_SHADOW_EN enables the shadow_cfg register; when
//             undefined shadow_cfg is tied to zero.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_cfg_sequencer #(
  parameter logic       DEF_PARITY      = 1'b0,
  parameter logic       DEF_PARITY_TYPE = 1'b0,
  parameter logic       DEF_STOP_BITS   = 1'b0,
  parameter logic [3:0] DEF_FRAME_LEN   = 4'd8,
  parameter int         ACK_TIMEOUT     = 15
) (
  input  wire                   clk_16bd,
  input  wire                   rst,
  input  wire                   start,
  uart_cfg_sequencer_if.master  bus,
  output logic                  busy,
  output logic                  boot_done,
  output logic                  timeout_err,
  output logic [15:0]           shadow_cfg
);

  // Last count value before the write is abandoned: valid stays high for
  // exactly ACK_TIMEOUT cycles when no ack arrives.
  localparam logic [7:0] TMO_LAST = 8'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_BOOT  = 3'd1,
    S_BWAIT = 3'd2,
    S_GAP   = 3'd3,
    S_HOST  = 3'd4,
    S_HWAIT = 3'd5
  } state_t;

  state_t     state, state_nx;
  logic [2:0] index, index_nx;
  logic [7:0] tmo_cnt, tmo_cnt_nx;
  logic       valid_q, valid_nx;
  logic [3:0] addr_q, addr_nx;
  logic [3:0] data_q, data_nx;
  logic       host_done_q, host_done_nx;
  logic       host_mode, host_mode_nx;     // current write came from the host
  logic       start_pend, start_pend_nx;   // start seen during a host write
  logic       boot_done_q, boot_done_nx;
  logic       timeout_err_q, timeout_err_nx;
  logic [3:0] boot_data;
  logic       xfer_end;

  always_comb begin
    case (index[1:0])
      2'd0:    boot_data = {3'b000, DEF_PARITY};
      2'd1:    boot_data = {3'b000, DEF_PARITY_TYPE};
      2'd2:    boot_data = {3'b000, DEF_STOP_BITS};
      default: boot_data = DEF_FRAME_LEN;
    endcase
  end

  // A write finishes on ack or when the timeout count is exhausted.
  // Ack is only meaningful while valid is high.
  assign xfer_end = valid_q && (bus.cfg_ack || (tmo_cnt == TMO_LAST));

  always_ff @(posedge clk_16bd) begin
    if (rst) begin
      state         <= S_BOOT;
      index         <= 3'd0;
      tmo_cnt       <= 8'd0;
      valid_q       <= 1'b0;
      addr_q        <= 4'd0;
      data_q        <= 4'd0;
      host_done_q   <= 1'b0;
      host_mode     <= 1'b0;
      start_pend    <= 1'b0;
      boot_done_q   <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state         <= state_nx;
      index         <= index_nx;
      tmo_cnt       <= tmo_cnt_nx;
      valid_q       <= valid_nx;
      addr_q        <= addr_nx;
      data_q        <= data_nx;
      host_done_q   <= host_done_nx;
      host_mode     <= host_mode_nx;
      start_pend    <= start_pend_nx;
      boot_done_q   <= boot_done_nx;
      timeout_err_q <= timeout_err_nx;
    end
  end

  always_comb begin
    state_nx       = state;
    index_nx       = index;
    tmo_cnt_nx     = tmo_cnt;
    valid_nx       = valid_q;
    addr_nx        = addr_q;
    data_nx        = data_q;
    host_done_nx   = 1'b0;
    host_mode_nx   = host_mode;
    start_pend_nx  = start_pend;
    boot_done_nx   = boot_done_q;
    timeout_err_nx = timeout_err_q;

    case (state)
      S_IDLE: begin
        if (start || start_pend) begin
          state_nx       = S_BOOT;
          index_nx       = 3'd0;
          start_pend_nx  = 1'b0;
          boot_done_nx   = 1'b0;
          timeout_err_nx = 1'b0;
        end else if (bus.host_req) begin
          state_nx = S_HOST;
        end
      end
      S_BOOT: begin
        valid_nx   = 1'b1;
        addr_nx    = {2'b00, index[1:0]};
        data_nx    = boot_data;
        tmo_cnt_nx = 8'd0;
        state_nx   = S_BWAIT;
      end
      S_BWAIT: begin
        if (xfer_end) begin
          valid_nx = 1'b0;
          index_nx = index + 3'd1;
          if (!bus.cfg_ack) timeout_err_nx = 1'b1;
          state_nx = S_GAP;
        end else begin
          tmo_cnt_nx = tmo_cnt + 8'd1;
        end
      end
      S_GAP: begin
        if (host_mode) begin
          host_mode_nx = 1'b0;
          state_nx     = S_IDLE;
        end else if (index < 3'd4) begin
          state_nx = S_BOOT;
        end else begin
          boot_done_nx = 1'b1;
          state_nx     = S_IDLE;
        end
      end
      S_HOST: begin
        valid_nx     = 1'b1;
        addr_nx      = bus.host_addr;
        data_nx      = bus.host_data;
        tmo_cnt_nx   = 8'd0;
        host_mode_nx = 1'b1;
        state_nx     = S_HWAIT;
      end
      S_HWAIT: begin
        if (xfer_end) begin
          valid_nx     = 1'b0;
          host_done_nx = 1'b1;
          if (!bus.cfg_ack) timeout_err_nx = 1'b1;
          state_nx = S_GAP;
        end else begin
          tmo_cnt_nx = tmo_cnt + 8'd1;
        end
      end
      default: state_nx = S_IDLE;
    endcase

    // A start that lands anywhere in a host write is remembered and
    // taken at the next IDLE; starts during boot are dropped.
    if (start && ((state == S_HOST) || (state == S_HWAIT) ||
                  ((state == S_GAP) && host_mode)))
      start_pend_nx = 1'b1;
  end

  assign bus.cfg_valid = valid_q;
  assign bus.cfg_addr  = addr_q;
  assign bus.cfg_data  = data_q;
  assign bus.host_done = host_done_q;
  assign busy          = (state != S_IDLE);
  assign boot_done     = boot_done_q;
  assign timeout_err   = timeout_err_q;

`ifdef UART_CFG_SHADOW_EN
  // Mirrors the last write (acked or timed out) to addresses 0..3.
  logic [15:0] shadow_q;

  always_ff @(posedge clk_16bd) begin
    if (rst) begin
      shadow_q <= 16'h0000;
    end else if (xfer_end && (addr_q[3:2] == 2'b00)) begin
      case (addr_q[1:0])
        2'd0:    shadow_q[0]   <= data_q[0];
        2'd1:    shadow_q[1]   <= data_q[0];
        2'd2:    shadow_q[2]   <= data_q[0];
        default: shadow_q[7:4] <= data_q;
      endcase
    end
  end

  assign shadow_cfg = shadow_q;
`else
  assign shadow_cfg = 16'h0000;
`endif

endmodule

`default_nettype wire
